// File: rtl/theta_slice_if.sv
// Slice stream handshake bundle for the theta engine.
// Load side, drain side and frame status in one place.
interface theta_slice_if #(
  parameter int ZW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [24:0]   in_slice;
  logic          bypass;
  logic          out_valid;
  logic          out_ready;
  logic [24:0]   out_slice;
  logic [ZW-1:0] out_idx;
  logic          frame_done;
  logic          busy;

  modport slave (
    input  in_valid, in_slice, bypass, out_ready,
    output in_ready, out_valid, out_slice, out_idx,
    output frame_done, busy
  );

  modport master (
    output in_valid, in_slice, bypass, out_ready,
    input  in_ready, out_valid, out_slice, out_idx,
    input  frame_done, busy
  );
endinterface

// File: rtl/theta_slice_unit.sv
// Keccak theta step, one 25-bit slice per cycle.
// Loads a full state, then streams theta(state) by z.
module theta_slice_unit #(
  parameter int LANE_W = 64,
  localparam int ZW = (LANE_W > 1) ? $clog2(LANE_W) : 1
) (
  input logic          clk,
  input logic          rst,
  theta_slice_if.slave s
);
  typedef enum logic [1:0] {IDLE, LOAD, OUT} state_t;

  localparam logic [ZW-1:0] LAST = ZW'(LANE_W - 1);

  state_t        state;
  logic [ZW-1:0] z;
  logic          mode;
  logic          in_rdy;
  logic          out_vld;
  logic          done_q;
  logic          busy_q;

  logic [24:0]   slice_buf [LANE_W];
  logic [4:0]    par [LANE_W];

  logic          in_acc;
  logic          out_acc;
  logic [ZW-1:0] zp;
  logic [4:0]    cin;
  logic [4:0]    d;
  logic [24:0]   cur;
  logic [24:0]   out_s;

  assign in_acc  = in_rdy & s.in_valid;
  assign out_acc = out_vld & s.out_ready;
  assign zp      = (LANE_W == 1) ? z : z - ZW'(1);

  assign s.in_ready   = in_rdy;
  assign s.out_valid  = out_vld;
  assign s.out_idx    = z;
  assign s.frame_done = done_q;
  assign s.busy       = busy_q;
  assign s.out_slice  = out_s;

  // Column parity of the incoming slice
  always_comb begin
    cin = '0;
    for (int x = 0; x < 5; x++) begin
      cin[x] = s.in_slice[x] ^ s.in_slice[x+5]
             ^ s.in_slice[x+10] ^ s.in_slice[x+15]
             ^ s.in_slice[x+20];
    end
  end

  // Control FSM: load LANE_W slices, then drain LANE_W
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      z       <= '0;
      mode    <= 1'b0;
      in_rdy  <= 1'b1;
      out_vld <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, LOAD: begin
          if (in_acc) begin
            if (state == IDLE) mode <= s.bypass;
            busy_q <= 1'b1;
            if (z == LAST) begin
              state   <= OUT;
              z       <= '0;
              in_rdy  <= 1'b0;
              out_vld <= 1'b1;
            end else begin
              state <= LOAD;
              z     <= z + ZW'(1);
            end
          end
        end
        OUT: begin
          if (out_acc) begin
            if (z == LAST) begin
              state   <= IDLE;
              z       <= '0;
              done_q  <= 1'b1;
              in_rdy  <= 1'b1;
              out_vld <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              z <= z + ZW'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          z       <= '0;
          in_rdy  <= 1'b1;
          out_vld <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Slice and parity storage, written only on accept
  always_ff @(posedge clk) begin
    if (in_acc) begin
      slice_buf[z] <= s.in_slice;
      par[z]       <= cin;
    end
  end

  // Theta mix of the current slice with neighbouring parities
  always_comb begin
    d   = '0;
    cur = slice_buf[z];
    if (!mode) begin
      for (int x = 0; x < 5; x++) begin
        d[x] = par[z][(x+4)%5] ^ par[zp][(x+1)%5];
      end
    end
    out_s = cur;
    for (int i = 0; i < 25; i++) begin
      out_s[i] = cur[i] ^ d[i%5];
    end
  end
endmodule

// File: tb/tb_theta_slice_unit.sv
// Directed bench for theta_slice_unit.
// Covers LANE_W of 4, 64 and 1.
module tb_theta_slice_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  theta_slice_if #(.ZW(2)) i4 ();
  theta_slice_if #(.ZW(6)) i64 ();
  theta_slice_if #(.ZW(1)) i1 ();

  theta_slice_unit #(.LANE_W(4)) u4 (
    .clk(clk), .rst(rst), .s(i4.slave)
  );
  theta_slice_unit #(.LANE_W(64)) u64 (
    .clk(clk), .rst(rst), .s(i64.slave)
  );
  theta_slice_unit #(.LANE_W(1)) u1 (
    .clk(clk), .rst(rst), .s(i1.slave)
  );

  logic [24:0] res4 [4];
  logic [24:0] a64 [64];
  logic [24:0] e64 [64];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic run4(input logic [24:0] a0, a1, a2, a3,
                      input logic byp, input string tag);
    logic [24:0] a [4];
    int got;
    a = '{a0, a1, a2, a3};
    for (int k = 0; k < 4; k++) res4[k] = 25'h1555555;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i4.in_valid = 1'b1;
      i4.in_slice = a[i];
      i4.bypass   = (i == 0) ? byp : ~byp;
    end
    @(negedge clk);
    i4.in_valid = 1'b0;
    i4.bypass   = 1'b0;
    chk({tag, ".lat"}, 32'(i4.out_valid), 1);
    chk({tag, ".inrdy"}, 32'(i4.in_ready), 0);
    i4.out_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 40 && got < 4; t++) begin
      if (i4.out_valid) begin
        chk({tag, ".idx"}, 32'(i4.out_idx), got);
        res4[i4.out_idx] = i4.out_slice;
        got++;
      end
      @(negedge clk);
    end
    chk({tag, ".cnt"}, got, 4);
    chk({tag, ".done"}, 32'(i4.frame_done), 1);
    i4.out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".done1"}, 32'(i4.frame_done), 0);
    chk({tag, ".ovlo"}, 32'(i4.out_valid), 0);
  endtask

  task automatic run64(input logic byp);
    logic [4:0]  c [64];
    logic [4:0]  dd;
    logic [24:0] hs;
    logic [5:0]  hi;
    int got, fd, gap, zm;
    bit hold, rdy;
    for (int z = 0; z < 64; z++) begin
      a64[z] = 25'($urandom);
      for (int x = 0; x < 5; x++) begin
        c[z][x] = a64[z][x] ^ a64[z][x+5] ^ a64[z][x+10]
                ^ a64[z][x+15] ^ a64[z][x+20];
      end
    end
    for (int z = 0; z < 64; z++) begin
      zm = (z + 63) % 64;
      for (int x = 0; x < 5; x++) begin
        dd[x] = byp ? 1'b0 : (c[z][(x+4)%5] ^ c[zm][(x+1)%5]);
      end
      for (int i = 0; i < 25; i++) e64[z][i] = a64[z][i] ^ dd[i%5];
    end
    for (int z = 0; z < 64; z++) begin
      @(negedge clk);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        i64.in_valid  = 1'b0;
        i64.in_slice  = 25'($urandom);
        i64.out_ready = 1'($urandom);
        @(negedge clk);
      end
      i64.in_valid = 1'b1;
      i64.in_slice = a64[z];
      i64.bypass   = (z == 0) ? byp : 1'($urandom);
    end
    @(negedge clk);
    i64.in_valid = 1'b0;
    got = 0;
    fd = 0;
    hold = 0;
    hs = '0;
    hi = '0;
    for (int t = 0; t < 1000 && got < 64; t++) begin
      if (i64.frame_done) fd++;
      if (i64.out_valid) begin
        chk("bp.inrdy", 32'(i64.in_ready), 0);
        if (hold) begin
          chk("bp.hold", 32'(i64.out_slice), 32'(hs));
          chk("bp.holdidx", 32'(i64.out_idx), 32'(hi));
        end
        rdy = 1'($urandom_range(0, 1));
        i64.out_ready = rdy;
        i64.in_valid  = (rdy && got == 63) ? 1'b0 : 1'($urandom);
        i64.in_slice  = 25'($urandom);
        if (rdy) begin
          chk("bp.idx", 32'(i64.out_idx), got);
          chk("bp.data", 32'(i64.out_slice), 32'(e64[got]));
          got++;
          hold = 0;
        end else begin
          hold = 1;
          hs = i64.out_slice;
          hi = i64.out_idx;
        end
      end
      @(negedge clk);
    end
    i64.in_valid = 1'b0;
    chk("bp.cnt", got, 64);
    repeat (3) begin
      if (i64.frame_done) fd++;
      @(negedge clk);
    end
    i64.out_ready = 1'b0;
    chk("bp.fd", fd, 1);
    chk("bp.busy", 32'(i64.busy), 0);
  endtask

  initial begin
    i4.in_valid = 0;  i4.in_slice = '0;
    i4.bypass = 0;    i4.out_ready = 0;
    i64.in_valid = 0; i64.in_slice = '0;
    i64.bypass = 0;   i64.out_ready = 0;
    i1.in_valid = 0;  i1.in_slice = '0;
    i1.bypass = 0;    i1.out_ready = 0;

    #12;
    chk("rst.inrdy", 32'(i4.in_ready), 1);
    chk("rst.ov", 32'(i4.out_valid), 0);
    chk("rst.idx", 32'(i4.out_idx), 0);
    chk("rst.fd", 32'(i4.frame_done), 0);
    chk("rst.busy", 32'(i4.busy), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      i4.in_valid = 1'b1;
      i4.in_slice = 25'h1FFFFFF;
    end
    @(negedge clk);
    i4.in_valid = 1'b0;
    chk("mid.busy", 32'(i4.busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid.inrdy", 32'(i4.in_ready), 1);
    chk("mid.ov", 32'(i4.out_valid), 0);
    chk("mid.busy0", 32'(i4.busy), 0);
    @(negedge clk);
    rst = 1'b1;

    run4(25'h0000001, 25'h0, 25'h0, 25'h0, 1'b0, "sb");
    chk("sb.z0", 32'(res4[0]), 32'h0210843);
    chk("sb.z1", 32'(res4[1]), 32'h1084210);
    chk("sb.z2", 32'(res4[2]), 32'h0);
    chk("sb.z3", 32'(res4[3]), 32'h0);

    run4(25'h0, 25'h0, 25'h0, 25'h0000001, 1'b0, "wr");
    chk("wr.z0", 32'(res4[0]), 32'h1084210);
    chk("wr.z1", 32'(res4[1]), 32'h0);
    chk("wr.z2", 32'(res4[2]), 32'h0);
    chk("wr.z3", 32'(res4[3]), 32'h0210843);

    run4(25'h0000001, 25'h0, 25'h0, 25'h0, 1'b1, "by");
    chk("by.z0", 32'(res4[0]), 32'h0000001);
    chk("by.z1", 32'(res4[1]), 32'h0);
    chk("by.z2", 32'(res4[2]), 32'h0);
    chk("by.z3", 32'(res4[3]), 32'h0);

    run64(1'b0);
    run64(1'b0);
    run64(1'b1);

    @(negedge clk);
    i1.in_valid = 1'b1;
    i1.in_slice = 25'h0000001;
    i1.bypass   = 1'b0;
    @(negedge clk);
    chk("l1.ov", 32'(i1.out_valid), 1);
    chk("l1.inrdy", 32'(i1.in_ready), 0);
    chk("l1.d0", 32'(i1.out_slice), 32'h1294A53);
    chk("l1.idx", 32'(i1.out_idx), 0);
    i1.out_ready = 1'b1;
    i1.in_slice  = 25'h1FFFFFF;
    @(negedge clk);
    chk("l1.fd", 32'(i1.frame_done), 1);
    chk("l1.inrdy2", 32'(i1.in_ready), 1);
    i1.in_slice = 25'h0000020;
    @(negedge clk);
    i1.in_valid = 1'b0;
    chk("l1.ov2", 32'(i1.out_valid), 1);
    chk("l1.d1", 32'(i1.out_slice), 32'h1294A72);
    @(negedge clk);
    chk("l1.fd2", 32'(i1.frame_done), 1);
    i1.out_ready = 1'b0;
    @(negedge clk);
    chk("l1.idle", 32'(i1.out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/theta_slice_unit.md
# theta_slice_unit

Parametrised Keccak theta-step engine working slice by slice. It accepts a full state as LANE_W 25-bit slices over a valid/ready stream and buffers them internally. It builds the per-slice column parities during the load phase, then streams out the theta-transformed slices. It generalises the fixed 64-slice serial column-parity datapath: lane width is a parameter, a bypass mode is added, column parity is computed in one cycle per slice, and flow control is a handshake rather than external controller strobes.

## Interface
- LANE_W, 64, slices per state (lane width); power of two, 1..64
- ZW, $clog2(LANE_W) (min 1), slice index width (localparam)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  in_slice holds a valid slice
- in_ready  output  1  block accepts a slice this cycle
- in_slice  input  25  slice; bit 5*y+x = A[x][y]
- bypass  input  1  1 = output slices unmodified; sampled on the first accepted slice
- out_valid  output  1  out_slice is valid
- out_ready  input  1  consumer accepts out_slice
- out_slice  output  25  transformed slice, same bit order
- out_idx  output  ZW  z index of out_slice
- frame_done  output  1  one-cycle pulse on acceptance of the last output slice
- busy  output  1  high in every state except IDLE

## Operation
- Storage: slice buffer of LANE_W x 25 bits; parity register C of LANE_W x 5 bits; z counter (ZW bits); mode register.
- States:
  - IDLE: in_ready=1. The first accept writes slice z=0 and latches bypass into the mode register, then moves to LOAD. If LANE_W=1, it moves to OUT instead.
  - LOAD: in_ready=1. Each accept writes buf[z]=in_slice and C[z][x]=XOR over y of in_slice[5*y+x]. z increments. The accept with z=LANE_W-1 moves to OUT and clears z.
  - OUT: in_ready=0, out_valid=1, out_idx=z.
    - out_slice[5*y+x] = buf[z][5*y+x] ^ D[x], with D[x] = C[z][(x+4)%5] ^ C[(z-1) mod LANE_W][(x+1)%5].
    - In bypass mode, D=0.
    - Each accept increments z. The accept at z=LANE_W-1 pulses frame_done, clears z and returns to IDLE.
- The z-1 index wraps: z=0 uses C[LANE_W-1]. For LANE_W=1, z-1 = z.
- in_valid is ignored in OUT; nothing is written. in_slice is don't-care when in_valid=0.
- out_ready is ignored when out_valid=0.
- Buffer and C contents are not cleared between frames. Every entry is rewritten before it is read.

## Timing
- Reset values: state IDLE, z=0, mode=0, in_ready=1, out_valid=0, out_idx=0, frame_done=0, busy=0. Buffer and C contents are undefined after reset.
- Reset mid-frame aborts the frame. No output from a partial frame ever appears.
- Throughput is one slice per cycle in each direction when the handshake is held high.
- Latency: out_valid rises in the cycle after the last input accept. A full frame takes LANE_W cycles in and LANE_W cycles out, with no gap back to IDLE. The next frame's first accept can occur in the cycle after frame_done.
- Back-pressure:
  - With out_ready low, out_slice and out_idx hold stable.
  - With in_valid low in LOAD, the state waits indefinitely with no timeout.
- out_slice is combinational from buf, C and z. out_valid, out_idx, frame_done and in_ready derive from registered state only; none depends combinationally on in_valid or out_ready.
- The bypass pin is sampled only on the first accept. Changes mid-frame have no effect.

## Test plan
- Reset state: rst=0 asynchronously mid-LOAD (LANE_W=4, after 2 slices) → immediately in_ready=1, out_valid=0, busy=0. Then a full 4-slice frame yields exactly 4 outputs, out_idx 0..3.
- Single-bit theta (LANE_W=4): slices z0=0x0000001, z1..z3=0 → out z0=0x0210843, z1=0x1084210, z2=0x0000000, z3=0x0000000.
- Wrap-around (LANE_W=4): z3=0x0000001, others 0 → out z3=0x0210843, z0=0x1084210 (C[z-1] wraps), z1=z2=0.
- Bypass: the same stimulus as the single-bit case with bypass=1 on the first accept (then toggled to 0) → outputs equal the inputs exactly: 0x0000001, 0, 0, 0.
- Back-pressure: random out_ready/in_valid gaps with LANE_W=64 and a random state → outputs match a reference theta model. out_slice is stable while out_ready=0. frame_done pulses once per frame. in_ready=0 throughout OUT.
- LANE_W=1: in 0x0000001 → out 0x1294A53 (D[1] and D[4] both 1, z-1 = z). Back-to-back frames have no idle gap beyond one IDLE cycle.
